// File: rtl/i2c_master_ctrl.sv
// i2c_master_ctrl: single-master, push-pull-SCL I2C controller for register
// style transfers (device address, 0..4 register-address bytes, 1..4 data bytes).
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   start_i           transaction request, accepted only while busy=0
//   rw, id            direction (1 = read) and 7-bit target address
//   add_nbyte         register-address byte count (clamped to 0..4)
//   data_nbyte        data byte count (0 -> 1, clamped to 1..4)
//   addr, wdata       right-aligned register address / write data
//   rdata             right-aligned read data
//   busy, done, nack  status; done is a one-cycle pulse, nack valid with done
//   scl, sdo, sdo_en  bus drive (sdo_en=0 releases SDA)
//   sdi               sampled SDA pad
//   state_o           current FSM state for debug
//
// state  | meaning
// IDLE   | bus idle, waiting for start_i
// START  | start condition
// DEVA   | device address byte (write, or read when no register address)
// ACKD   | slave ACK for DEVA
// REGA   | register-address byte
// ACKR   | slave ACK for REGA
// WRD    | write-data byte
// ACKW   | slave ACK for WRD
// RSTART | repeated start before the read phase
// DEVR   | device address byte with R/W=1
// ACKD2  | slave ACK for DEVR
// RDD    | read-data byte from slave
// MACK   | master ACK/NACK after a read byte
// STOP   | stop condition
module i2c_master_ctrl #(
    parameter int unsigned QTR = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic        rw,
    input  logic [6:0]  id,
    input  logic [3:0]  add_nbyte,
    input  logic [3:0]  data_nbyte,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        done,
    output logic        nack,
    output logic        scl,
    output logic        sdo,
    output logic        sdo_en,
    input  logic        sdi,
    output logic [3:0]  state_o
);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,  START = 4'd1,  DEVA  = 4'd2,  ACKD = 4'd3,
        REGA   = 4'd4,  ACKR  = 4'd5,  WRD   = 4'd6,  ACKW = 4'd7,
        RSTART = 4'd8,  DEVR  = 4'd9,  ACKD2 = 4'd10, RDD  = 4'd11,
        MACK   = 4'd12, STOP  = 4'd13
    } state_t;

    localparam logic [7:0] QTR_M1 = 8'(QTR - 1);

    state_t      state_q, state_d;
    logic [7:0]  qcnt_q, qcnt_d;
    logic [1:0]  qtr_q, qtr_d;
    logic [2:0]  bit_q, bit_d;
    logic [1:0]  idx_q, idx_d;
    logic        rw_q, rw_d;
    logic [6:0]  id_q, id_d;
    logic [2:0]  acnt_q, acnt_d;
    logic [2:0]  dcnt_q, dcnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        ack_q, ack_d;
    logic        nack_q, nack_d;
    logic        done_q, done_d;

    logic [2:0]  a_clamp, d_clamp;
    logic        qtr_end, seg_end, sample_now;
    logic [7:0]  cur_byte;

    assign a_clamp    = (add_nbyte > 4'd4) ? 3'd4 : add_nbyte[2:0];
    assign d_clamp    = (data_nbyte == 4'd0) ? 3'd1 :
                        (data_nbyte > 4'd4) ? 3'd4 : data_nbyte[2:0];
    assign qtr_end    = (qcnt_q == 8'd0);
    assign seg_end    = qtr_end && (qtr_q == 2'd3);
    assign sample_now = qtr_end && (qtr_q == 2'd2);

    // Byte currently on the wire; bit_q counts 7..0 so MSB goes first.
    always_comb begin
        cur_byte = 8'h00;
        case (state_q)
            DEVA:    cur_byte = {id_q, rw_q & (acnt_q == 3'd0)};
            DEVR:    cur_byte = {id_q, 1'b1};
            REGA:    cur_byte = addr_q[{idx_q, 3'b000} +: 8];
            WRD:     cur_byte = wdata_q[{idx_q, 3'b000} +: 8];
            default: cur_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_d = state_q;
        qcnt_d  = qcnt_q;
        qtr_d   = qtr_q;
        bit_d   = bit_q;
        idx_d   = idx_q;
        rw_d    = rw_q;
        id_d    = id_q;
        acnt_d  = acnt_q;
        dcnt_d  = dcnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ack_d   = ack_q;
        nack_d  = nack_q;
        done_d  = 1'b0;
        if (state_q == IDLE) begin
            if (start_i) begin
                state_d = START;
                rw_d    = rw;
                id_d    = id;
                acnt_d  = a_clamp;
                dcnt_d  = d_clamp;
                addr_d  = addr;
                wdata_d = wdata;
                rdata_d = 32'h0;
                nack_d  = 1'b0;
                qcnt_d  = QTR_M1;
                qtr_d   = 2'd0;
                bit_d   = 3'd7;
            end
        end else begin
            if (qtr_end) begin
                qcnt_d = QTR_M1;
                qtr_d  = qtr_q + 2'd1;
            end else begin
                qcnt_d = qcnt_q - 8'd1;
            end
            if (sample_now) begin
                ack_d = sdi;
                if (state_q == RDD) rdata_d = {rdata_q[30:0], sdi};
            end
            if (seg_end) begin
                bit_d = 3'd7;
                case (state_q)
                    START:  state_d = DEVA;
                    DEVA, REGA, WRD, DEVR, RDD: begin
                        if (bit_q != 3'd0) begin
                            bit_d = bit_q - 3'd1;
                        end else begin
                            case (state_q)
                                DEVA:    state_d = ACKD;
                                REGA:    state_d = ACKR;
                                WRD:     state_d = ACKW;
                                DEVR:    state_d = ACKD2;
                                default: state_d = MACK;
                            endcase
                        end
                    end
                    ACKD: begin
                        if (ack_q) begin
                            state_d = STOP;
                            nack_d  = 1'b1;
                        end else if (acnt_q != 3'd0) begin
                            state_d = REGA;
                            idx_d   = 2'(acnt_q - 3'd1);
                        end else begin
                            state_d = rw_q ? RDD : WRD;
                            idx_d   = 2'(dcnt_q - 3'd1);
                        end
                    end
                    ACKR: begin
                        if (ack_q) begin
                            state_d = STOP;
                            nack_d  = 1'b1;
                        end else if (idx_q != 2'd0) begin
                            state_d = REGA;
                            idx_d   = idx_q - 2'd1;
                        end else if (rw_q) begin
                            state_d = RSTART;
                        end else begin
                            state_d = WRD;
                            idx_d   = 2'(dcnt_q - 3'd1);
                        end
                    end
                    ACKW: begin
                        if (ack_q) begin
                            state_d = STOP;
                            nack_d  = 1'b1;
                        end else if (idx_q != 2'd0) begin
                            state_d = WRD;
                            idx_d   = idx_q - 2'd1;
                        end else begin
                            state_d = STOP;
                        end
                    end
                    RSTART: state_d = DEVR;
                    ACKD2: begin
                        if (ack_q) begin
                            state_d = STOP;
                            nack_d  = 1'b1;
                        end else begin
                            state_d = RDD;
                            idx_d   = 2'(dcnt_q - 3'd1);
                        end
                    end
                    MACK: begin
                        if (idx_q != 2'd0) begin
                            state_d = RDD;
                            idx_d   = idx_q - 2'd1;
                        end else begin
                            state_d = STOP;
                        end
                    end
                    STOP: begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        qcnt_d  = 8'd0;
                        qtr_d   = 2'd0;
                        idx_d   = 2'd0;
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            qcnt_q  <= 8'd0;
            qtr_q   <= 2'd0;
            bit_q   <= 3'd0;
            idx_q   <= 2'd0;
            rw_q    <= 1'b0;
            id_q    <= 7'd0;
            acnt_q  <= 3'd0;
            dcnt_q  <= 3'd0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            ack_q   <= 1'b0;
            nack_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            qcnt_q  <= qcnt_d;
            qtr_q   <= qtr_d;
            bit_q   <= bit_d;
            idx_q   <= idx_d;
            rw_q    <= rw_d;
            id_q    <= id_d;
            acnt_q  <= acnt_d;
            dcnt_q  <= dcnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            nack_q  <= nack_d;
            done_q  <= done_d;
        end
    end

    // Bus drive is decoded from state and quarter so reset releases the bus
    // in the same instant the state register clears.
    always_comb begin
        scl    = 1'b1;
        sdo    = 1'b1;
        sdo_en = 1'b0;
        case (state_q)
            START, RSTART: begin
                scl = (qtr_q != 2'd0);
                if (qtr_q[1]) begin
                    sdo_en = 1'b1;
                    sdo    = 1'b0;
                end
            end
            STOP: begin
                scl = (qtr_q != 2'd0);
                if (!qtr_q[1]) begin
                    sdo_en = 1'b1;
                    sdo    = 1'b0;
                end
            end
            DEVA, REGA, WRD, DEVR: begin
                scl    = qtr_q[1];
                sdo_en = 1'b1;
                sdo    = cur_byte[bit_q];
            end
            ACKD, ACKR, ACKW, ACKD2, RDD: scl = qtr_q[1];
            MACK: begin
                scl = qtr_q[1];
                // Last read byte is NACKed by leaving SDA released.
                if (idx_q != 2'd0) begin
                    sdo_en = 1'b1;
                    sdo    = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign nack    = nack_q;
    assign rdata   = rdata_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// tb_i2c_master_ctrl: directed scoreboard bench for i2c_master_ctrl (QTR=2).
// A bus decoder/slave model reports START/STOP, master-sent bytes and master
// ACK/NACK as events; a done monitor checks latency, nack and rdata.
module tb_i2c_master_ctrl;
    localparam int EV_S    = 256;
    localparam int EV_P    = 257;
    localparam int EV_ACK  = 258;
    localparam int EV_NACK = 259;
    localparam logic [6:0] SL_ID = 7'h23;

    typedef struct {
        int          lat;
        logic        nk;
        logic [31:0] rd;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic        rw = 1'b0;
    logic [6:0]  id = 7'h0;
    logic [3:0]  add_nbyte = 4'h0;
    logic [3:0]  data_nbyte = 4'h0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata;
    logic        busy, done, nack, scl, sdo, sdo_en, sdi;
    logic [3:0]  state_o;
    logic        sl_sda = 1'b1;
    logic        sda_line;

    assign sda_line = sdo_en ? sdo : sl_sda;
    assign sdi      = sda_line;

    i2c_master_ctrl #(.QTR(2)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .rw(rw), .id(id),
        .add_nbyte(add_nbyte), .data_nbyte(data_nbyte), .addr(addr), .wdata(wdata),
        .rdata(rdata), .busy(busy), .done(done), .nack(nack), .scl(scl),
        .sdo(sdo), .sdo_en(sdo_en), .sdi(sdi), .state_o(state_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          total = 0;
    int          bad = 0;
    int          exp_ev[$];
    int          acc_q[$];
    resp_t       resp_q[$];
    logic [7:0]  rd_q[$];
    bit          mon_en = 1'b1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic bus_ev(input int v);
        int e;
        total++;
        if (exp_ev.size() == 0) begin
            bad++;
            $display("FAIL bus_extra got=%0h want=none", v);
        end else begin
            e = exp_ev.pop_front();
            if (e != v) begin
                bad++;
                $display("FAIL bus_event got=%0h want=%0h", v, e);
            end
        end
    endtask

    // Bus decoder + slave model, evaluated mid-cycle so master edges are settled.
    logic       sc_p = 1'b1, sd_p = 1'b1, sc_n, sd_n;
    int         bitpos = 0;
    bit         first = 0, addressed = 0, rd_mode = 0, sending = 0, ackbit = 0;
    logic [7:0] shr = 8'h0, txb = 8'h0;

    always @(negedge clk) begin
        sc_n = scl;
        sd_n = sda_line;
        if (!rst_n || !mon_en) begin
            bitpos = 0; first = 0; addressed = 0; rd_mode = 0; sending = 0;
            sl_sda = 1'b1;
        end else if (sc_p && sc_n && sd_p && !sd_n) begin
            bus_ev(EV_S);
            bitpos = 0; first = 1; sending = 0; sl_sda = 1'b1;
        end else if (sc_p && sc_n && !sd_p && sd_n) begin
            bus_ev(EV_P);
            bitpos = 0; first = 0; addressed = 0; sending = 0; sl_sda = 1'b1;
        end else if (!sc_p && sc_n) begin
            if (bitpos < 8) begin
                shr = {shr[6:0], sd_n};
                bitpos++;
            end else if (bitpos == 8) begin
                if (sending) bus_ev(sd_n ? EV_NACK : EV_ACK);
                ackbit = sd_n;
                bitpos = 9;
            end
        end else if (sc_p && !sc_n) begin
            if (bitpos == 8) begin
                if (sending) begin
                    sl_sda = 1'b1;
                end else begin
                    bus_ev(int'(shr));
                    if (first) begin
                        addressed = (shr[7:1] == SL_ID);
                        rd_mode   = shr[0];
                        first     = 0;
                    end
                    sl_sda = addressed ? 1'b0 : 1'b1;
                end
            end else if (bitpos == 9) begin
                bitpos = 0;
                sl_sda = 1'b1;
                if (sending) begin
                    if (!ackbit) begin
                        txb    = (rd_q.size() != 0) ? rd_q.pop_front() : 8'hFF;
                        sl_sda = txb[7];
                    end else begin
                        sending = 0;
                    end
                end else if (addressed && rd_mode) begin
                    txb     = (rd_q.size() != 0) ? rd_q.pop_front() : 8'hFF;
                    sl_sda  = txb[7];
                    sending = 1;
                end
            end else if (sending && bitpos >= 1 && bitpos <= 7) begin
                sl_sda = txb[7 - bitpos];
            end
        end
        sc_p = sc_n;
        sd_p = sd_n;
    end

    // Completion monitor.
    logic  done_p = 1'b0;
    resp_t r_pop;
    int    a_pop;
    always @(negedge clk) begin
        if (!rst_n) begin
            done_p = 1'b0;
        end else begin
            if (done) begin
                chk("done_width", {31'b0, done_p}, 32'd0);
                chk("busy_at_done", {31'b0, busy}, 32'd0);
                if (resp_q.size() == 0 || acc_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL done_extra got=1 want=0");
                end else begin
                    r_pop = resp_q.pop_front();
                    a_pop = acc_q.pop_front();
                    chk("latency", 32'(cyc - a_pop), 32'(r_pop.lat));
                    chk("nack", {31'b0, nack}, {31'b0, r_pop.nk});
                    chk("rdata", rdata, r_pop.rd);
                end
            end
            done_p = done;
        end
    end

    task automatic start_txn(input logic r, input logic [6:0] i, input logic [3:0] an,
                             input logic [3:0] dn, input logic [31:0] a, input logic [31:0] w,
                             input int lat, input logic nk, input logic [31:0] rd);
        resp_t e;
        @(negedge clk);
        rw = r; id = i; add_nbyte = an; data_nbyte = dn; addr = a; wdata = w;
        start_i = 1'b1;
        rst_n = 1'b1;
        e.lat = lat; e.nk = nk; e.rd = rd;
        resp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0;
        acc_q.push_back(cyc);
        chk("busy_after_accept", {31'b0, busy}, 32'd1);
    endtask

    task automatic wait_done(input string nm);
        bit seen;
        seen = 0;
        for (int k = 0; k < 3000 && !seen; k++) begin
            @(negedge clk);
            seen = done;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL %s_timeout got=no_done want=done", nm);
        end
        @(negedge clk);
    endtask

    task automatic expect_clear(input string nm);
        chk(nm, 32'(exp_ev.size()), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1);
    end

    initial begin
        bit hit;
        repeat (3) @(negedge clk);
        chk("rst_scl", {31'b0, scl}, 32'd1);
        chk("rst_sdo_en", {31'b0, sdo_en}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_state", {28'b0, state_o}, 32'd0);

        // Write, A=2 D=2
        exp_ev = '{EV_S, 'h46, 'h00, 'h10, 'hAB, 'hCD, EV_P};
        start_txn(1'b0, 7'h23, 4'd2, 4'd2, 32'h0010, 32'hABCD, 376, 1'b0, 32'h0);
        wait_done("wr1");

        // Read, A=2 D=2, repeated start then 0x47
        expect_clear("left_wr1");
        exp_ev = '{EV_S, 'h46, 'h00, 'h00, EV_S, 'h47, EV_ACK, EV_NACK, EV_P};
        rd_q = '{8'h45, 8'h46};
        start_txn(1'b1, 7'h23, 4'd2, 4'd2, 32'h0000, 32'h0, 456, 1'b0, 32'h00004546);
        wait_done("rd1");

        // Absent device: STOP right after ACKD
        expect_clear("left_rd1");
        exp_ev = '{EV_S, 'hA0, EV_P};
        start_txn(1'b0, 7'h50, 4'd1, 4'd1, 32'h0001, 32'h0002, 88, 1'b1, 32'h0);
        wait_done("nodev");
        chk("nack_hold", {31'b0, nack}, 32'd1);

        // Clamped counts with a start pulse while busy
        expect_clear("left_nodev");
        exp_ev = '{EV_S, 'h46, 'hDE, 'hAD, 'hBE, 'hEF, 'hA5, EV_P};
        start_txn(1'b0, 7'h23, 4'd9, 4'd0, 32'hDEADBEEF, 32'h000000A5, 448, 1'b0, 32'h0);
        chk("nack_clear", {31'b0, nack}, 32'd0);
        repeat (40) @(negedge clk);
        rw = 1'b1; id = 7'h11; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        chk("busy_after_pulse", {31'b0, busy}, 32'd1);
        wait_done("clamp");

        // Read with no register address: DEVA carries R/W=1
        expect_clear("left_clamp");
        exp_ev = '{EV_S, 'h47, EV_NACK, EV_P};
        rd_q = '{8'h3C};
        start_txn(1'b1, 7'h23, 4'd0, 4'd1, 32'h0, 32'h0, 160, 1'b0, 32'h0000003C);
        wait_done("rd0");

        // Read, A=1 D=3
        expect_clear("left_rd0");
        exp_ev = '{EV_S, 'h46, 'h07, EV_S, 'h47, EV_ACK, EV_ACK, EV_NACK, EV_P};
        rd_q = '{8'h11, 8'h22, 8'h33};
        start_txn(1'b1, 7'h23, 4'd1, 4'd3, 32'h7, 32'h0, 456, 1'b0, 32'h00112233);
        wait_done("rd3");

        // Reset asserted during WRD, then a fresh write
        expect_clear("left_rd3");
        exp_ev = '{EV_S, 'h46, 'h05, 'h12, 'h34, EV_P};
        start_txn(1'b0, 7'h23, 4'd1, 4'd2, 32'h5, 32'h1234, 0, 1'b0, 32'h0);
        hit = 0;
        for (int k = 0; k < 1000 && !hit; k++) begin
            @(negedge clk);
            hit = (state_o == 4'd6);
        end
        chk("reach_wrd", {31'b0, hit}, 32'd1);
        #2;
        mon_en = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("arst_scl", {31'b0, scl}, 32'd1);
        chk("arst_sdo", {31'b0, sdo}, 32'd1);
        chk("arst_sdo_en", {31'b0, sdo_en}, 32'd0);
        chk("arst_busy", {31'b0, busy}, 32'd0);
        chk("arst_done", {31'b0, done}, 32'd0);
        chk("arst_nack", {31'b0, nack}, 32'd0);
        chk("arst_rdata", rdata, 32'h0);
        chk("arst_state", {28'b0, state_o}, 32'd0);
        exp_ev.delete();
        acc_q.delete();
        resp_q.delete();
        repeat (2) @(negedge clk);
        mon_en = 1'b1;
        exp_ev = '{EV_S, 'h46, 'h05, 'h5A, EV_P};
        start_txn(1'b0, 7'h23, 4'd1, 4'd1, 32'h5, 32'h5A, 232, 1'b0, 32'h0);
        wait_done("post_rst");

        repeat (20) @(negedge clk);
        expect_clear("left_end");
        chk("resp_left", 32'(resp_q.size()), 32'd0);
        chk("rdq_left", 32'(rd_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/i2c_master_ctrl.md
I2C_MASTER_CTRL -- requirements
Module: i2c_master_ctrl

Interface
REQ-001 SHALL have parameter QTR, default 8, meaning clk cycles per SCL quarter-bit (legal range 2..255).
REQ-002 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start_i  input  1  transaction request, accepted only when busy=0.
REQ-005 SHALL have port rw  input  1  0 = write, 1 = read.
REQ-006 SHALL have port id  input  7  target slave address.
REQ-007 SHALL have port add_nbyte  input  4  number of register-address bytes; valid range 0..4, values >4 clamp to 4.
REQ-008 SHALL have port data_nbyte  input  4  number of data bytes; valid range 1..4, 0 treated as 1, values >4 clamp to 4.
REQ-009 SHALL have port addr  input  32  register address, right-aligned.
REQ-010 SHALL have port wdata  input  32  write data, right-aligned.
REQ-011 SHALL have port rdata  output  32  read data, right-aligned.
REQ-012 SHALL have port busy  output  1  transaction in progress.
REQ-013 SHALL have port done  output  1  one-cycle completion pulse.
REQ-014 SHALL have port nack  output  1  last transaction aborted on NACK; valid with done.
REQ-015 SHALL have port scl  output  1  I2C clock, push-pull, single master.
REQ-016 SHALL have port sdo  output  1  SDA drive value.
REQ-017 SHALL have port sdo_en  output  1  SDA drive enable; when 0 the pad is released (reads high).
REQ-018 SHALL have port sdi  input  1  sampled SDA pad value.
REQ-019 SHALL have port state_o  output  4  current FSM state encoding, for debug.

Function
REQ-020 SHALL latch rw, id, the clamped byte counts, addr and wdata on the accepting edge.
- busy rises the next cycle.
- start_i while busy=1 is ignored.
REQ-021 SHALL implement FSM states: IDLE, START, DEVA, ACKD, REGA, ACKR, WRD, ACKW, RSTART, DEVR, ACKD2, RDD, MACK, STOP.
REQ-022 SHALL build each bit from 4 quarters of QTR cycles:
- q0: scl=0, drive the new SDA value;
- q1: scl=0;
- q2: scl=1, sample sdi on the last cycle of q2;
- q3: scl=1.
REQ-023 SHALL form START and RSTART as one 4-quarter segment:
- q0/q1: sda released high, scl=0 in q0 and 1 in q1;
- q2/q3: sda driven 0 with scl=1;
- for START from idle the bus is already high.
REQ-024 SHALL form STOP as one 4-quarter segment: q0 scl=0, sda=0; q1 scl=1, sda=0; q2/q3 scl=1, sda released.
REQ-025 SHALL send bytes MSB first.
- Register address bytes go from byte add_nbyte-1 down to byte 0 of addr.
- Write data bytes go from byte data_nbyte-1 down to byte 0 of wdata.
REQ-026 SHALL use this write sequence: START, DEVA (id,0), ACKD, then per address byte REGA/ACKR, then per data byte WRD/ACKW, then STOP.
REQ-027 SHALL use this read sequence: START, DEVA (id,0), ACKD, address bytes, RSTART, DEVR (id,1), ACKD2, then per data byte RDD/MACK, then STOP.
- If add_nbyte=0 on a read: RSTART, DEVR and ACKD2 are skipped and DEVA carries R/W=1; RDD follows ACKD directly.
REQ-028 SHALL release sdo_en=0 during all slave ACK bits and RDD bits.
REQ-029 SHALL drive ACK (sdo=0) in MACK for every read byte except the last, which gets NACK (released).
REQ-030 SHALL shift read bits into rdata MSB first, and SHALL clear rdata to 0 at transaction accept.
REQ-031 SHALL, on sdi=1 sampled in ACKD, ACKR, ACKW or ACKD2:
- proceed directly to STOP;
- set nack=1 at done;
- hold rdata at its partial value.
REQ-032 SHALL assert done for exactly one cycle on the first cycle after the STOP q3 ends.
- busy falls in the same cycle.
- nack holds its value until the next accept, then clears.
REQ-033 SHALL take 4*QTR*(9*(1+A+D)+2) cycles for a full write, counted from the accept edge to done, plus 4*QTR*10 for a read with A>0. A and D are the clamped byte counts.
REQ-034 SHALL hold scl=1 and sdo_en=0 while IDLE.

Reset
REQ-035 SHALL, on rst_n=0 at any time including mid-transaction, immediately force:
- state IDLE; scl=1, sdo=1, sdo_en=0;
- busy=0, done=0, nack=0, rdata=0;
- all counters 0.
REQ-036 SHALL accept a new start_i on the first clk edge after rst_n deasserts.

Verification
REQ-037 Write, QTR=2, id=7'h23, A=2, addr=16'h0010, D=2, wdata=16'hABCD, with the slave model ACKing:
- bus carries 0x46, 0x00, 0x10, 0xAB, 0xCD;
- done arrives after 8*47=376 cycles; nack=0.
REQ-038 Read, id=7'h23, A=2, addr=16'h0000, D=2, with the model returning 0x45 then 0x46:
- RSTART appears after the address bytes, then DEVR byte 0x47;
- MACK is ACK then NACK; rdata=32'h00004546.
REQ-039 No device at id=7'h50 (ACKD samples 1):
- STOP immediately follows ACKD;
- done and nack are both 1 after 8*11=88 cycles (QTR=2).
REQ-040 start_i pulsed mid-transaction, and add_nbyte=9 / data_nbyte=0:
- the pulse has no effect;
- the counts clamp to 4 and 1, checked by bus byte count.
REQ-041 rst_n low during WRD:
- outputs take reset values asynchronously;
- a fresh write after release completes correctly.
